// File: rtl/wb_pkg.sv
// Shared types for the register-file write-back path.
// Default widths and the queued {rd, data} entry.
package wb_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Result producer handshake: valid/rd/data offered, ready returned.
// The master is the producing unit, the slave the write-back block.
interface regfile_writeback_if;
  import wb_pkg::*;

  logic              valid;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (
    output valid,
    output rd,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  rd,
    input  data,
    output ready
  );

endinterface

// File: rtl/wb_fifo.sv
// Circular write-back queue: two write ports, one read port, count.
// Optional WB_BYPASS_EN adds an age-ordered rd match lookup.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        push_n,
  input  wb_entry_t         push0,
  input  wb_entry_t         push1,
  input  logic              pop,
  output wb_entry_t         head,
  output logic [CW-1:0]     count
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] byp_rs,
  output logic              byp_hit,
  output logic [DATA_W-1:0] byp_data
`endif
);

  wb_entry_t     slot [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr1;

  assign wptr1 = wptr + PW'(1);
  assign head  = slot[rptr];

  // push0 is always the older entry when two arrive together
  always_ff @(posedge clk) begin
    if (push_n != 2'd0)
      slot[wptr] <= push0;
    if (push_n == 2'd2)
      slot[wptr1] <= push1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + PW'(push_n);
      if (pop)
        rptr <= rptr + PW'(1);
      count <= count + CW'(push_n) - CW'(pop);
    end
  end

`ifdef WB_BYPASS_EN
  // scan oldest to youngest so the last match wins
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count &&
          byp_rs != '0 &&
          slot[rptr + PW'(k)].rd == byp_rs) begin
        byp_hit  = 1'b1;
        byp_data = slot[rptr + PW'(k)].data;
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-back front end: ALU/MEM queue, one commit/clock.
// Optional WB_BYPASS_EN exposes a queued-result bypass lookup.
module regfile_writeback
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  regfile_writeback_if.slave alu,
  regfile_writeback_if.slave mem,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic [CW-1:0]     wb_count
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] byp_rs,
  output logic              byp_hit,
  output logic [DATA_W-1:0] byp_data
`endif
);

  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          mem_acc;
  logic          alu_acc;
  logic          pop;
  logic [1:0]    push_n;
  wb_entry_t     push0;
  wb_entry_t     push1;
  wb_entry_t     head;

  // readiness ignores the same-cycle pop
  assign free      = CW'(DEPTH) - count;
  assign mem.ready = free != '0;
  assign alu.ready = (free >= CW'(2)) ||
                     (free != '0 && !mem.valid);

  assign mem_acc = mem.valid && mem.ready;
  assign alu_acc = alu.valid && alu.ready;
  assign pop     = count != '0;

  always_comb begin
    push_n = {1'b0, mem_acc} + {1'b0, alu_acc};
    push0  = '{rd: alu.rd, data: alu.data};
    push1  = push0;
    if (mem_acc) begin
      push0 = '{rd: mem.rd, data: mem.data};
      push1 = '{rd: alu.rd, data: alu.data};
    end
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_n   (push_n),
    .push0    (push0),
    .push1    (push1),
    .pop      (pop),
    .head     (head),
    .count    (count)
`ifdef WB_BYPASS_EN
    ,
    .byp_rs   (byp_rs),
    .byp_hit  (byp_hit),
    .byp_data (byp_data)
`endif
  );

  assign wb_count = count;

  // outputs hold the last commit so idle rewrites are harmless
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_rd   <= '0;
      wb_data <= '0;
      wb_we   <= 1'b0;
    end else begin
      wb_we <= pop;
      if (pop) begin
        wb_rd   <= head.rd;
        wb_data <= head.data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback against a queue model.
// Bypass checks are compiled in when WB_BYPASS_EN is defined.
module tb_regfile_writeback;
  import wb_pkg::*;

  localparam int DEPTH = 2;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_writeback_if alu_if();
  regfile_writeback_if mem_if();

  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_we;
  logic [CW-1:0]     wb_count;
`ifdef WB_BYPASS_EN
  logic [ADDR_W-1:0] byp_rs;
  logic              byp_hit;
  logic [DATA_W-1:0] byp_data;
`endif

  regfile_writeback #(
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu      (alu_if),
    .mem      (mem_if),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .wb_we    (wb_we),
    .wb_count (wb_count)
`ifdef WB_BYPASS_EN
    ,
    .byp_rs   (byp_rs),
    .byp_hit  (byp_hit),
    .byp_data (byp_data)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  wb_entry_t         q[$];
  wb_entry_t         log_q[$];
  logic [ADDR_W-1:0] exp_rd;
  logic [DATA_W-1:0] exp_data;
  logic              exp_we;
  bit                cmp_en = 1'b0;

  function automatic bit m_mem_ready();
    return (DEPTH - q.size()) >= 1;
  endfunction

  function automatic bit m_alu_ready();
    int fr;
    fr = DEPTH - q.size();
    return fr >= 2 || (fr >= 1 && !mem_if.valid);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      exp_rd   <= '0;
      exp_data <= '0;
      exp_we   <= 1'b0;
    end else begin
      bit mr;
      bit ar;
      mr = m_mem_ready();
      ar = m_alu_ready();
      if (q.size() != 0) begin
        exp_rd   <= q[0].rd;
        exp_data <= q[0].data;
        exp_we   <= 1'b1;
        void'(q.pop_front());
      end else begin
        exp_we <= 1'b0;
      end
      if (mem_if.valid && mr)
        q.push_back('{rd: mem_if.rd, data: mem_if.data});
      if (alu_if.valid && ar)
        q.push_back('{rd: alu_if.rd, data: alu_if.data});
    end
  end

`ifdef WB_BYPASS_EN
  function automatic void m_byp(output bit h, output logic [DATA_W-1:0] d);
    h = 1'b0;
    d = '0;
    foreach (q[i]) begin
      if (byp_rs != '0 && q[i].rd == byp_rs) begin
        h = 1'b1;
        d = q[i].data;
      end
    end
  endfunction
`endif

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("wb_we", 32'(wb_we), 32'(exp_we));
      chk("wb_rd", 32'(wb_rd), 32'(exp_rd));
      chk("wb_data", 32'(wb_data), 32'(exp_data));
      chk("wb_count", 32'(wb_count), 32'(q.size()));
      chk("mem_ready", 32'(mem_if.ready), 32'(m_mem_ready()));
      chk("alu_ready", 32'(alu_if.ready), 32'(m_alu_ready()));
`ifdef WB_BYPASS_EN
      begin
        bit               h;
        logic [DATA_W-1:0] d;
        m_byp(h, d);
        chk("byp_hit", 32'(byp_hit), 32'(h));
        if (h)
          chk("byp_data", 32'(byp_data), 32'(d));
      end
`endif
    end
    if (rst_n && wb_we)
      log_q.push_back('{rd: wb_rd, data: wb_data});
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_if.valid = 1'b0;
    mem_if.valid = 1'b0;
  endtask

  task automatic put_mem(input logic [ADDR_W-1:0] rd,
                         input logic [DATA_W-1:0] d);
    mem_if.valid = 1'b1;
    mem_if.rd    = rd;
    mem_if.data  = d;
  endtask

  task automatic put_alu(input logic [ADDR_W-1:0] rd,
                         input logic [DATA_W-1:0] d);
    alu_if.valid = 1'b1;
    alu_if.rd    = rd;
    alu_if.data  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int mk;
    int ak;
    bit mr;
    bit ar;
    idle();
    alu_if.rd   = '0;
    alu_if.data = '0;
    mem_if.rd   = '0;
    mem_if.data = '0;
`ifdef WB_BYPASS_EN
    byp_rs = '0;
`endif

    // reset held with random traffic
    rst_n = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      alu_if.valid = 1'($urandom_range(0, 1));
      mem_if.valid = 1'($urandom_range(0, 1));
      alu_if.rd    = 5'($urandom);
      mem_if.rd    = 5'($urandom);
      alu_if.data  = 16'($urandom);
      mem_if.data  = 16'($urandom);
      @(negedge clk);
      chk("rst_wb_we", 32'(wb_we), 32'd0);
      chk("rst_wb_rd", 32'(wb_rd), 32'd0);
      chk("rst_wb_data", 32'(wb_data), 32'd0);
      chk("rst_wb_count", 32'(wb_count), 32'd0);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mem_ready", 32'(mem_if.ready), 32'd1);
    chk("rst_alu_ready", 32'(alu_if.ready), 32'd1);
    cmp_en = 1'b1;

    // single ALU write
    cyc();
    put_alu(5'd3, 16'h00A5);
    cyc();
    idle();
    @(negedge clk);
    chk("single_we_acc", 32'(wb_we), 32'd0);
    chk("single_cnt_acc", 32'(wb_count), 32'd1);
    cyc();
    @(negedge clk);
    chk("single_we", 32'(wb_we), 32'd1);
    chk("single_rd", 32'(wb_rd), 32'd3);
    chk("single_data", 32'(wb_data), 32'h00A5);
    cyc();
    @(negedge clk);
    chk("single_hold_we", 32'(wb_we), 32'd0);
    chk("single_hold_rd", 32'(wb_rd), 32'd3);
    chk("single_hold_data", 32'(wb_data), 32'h00A5);

    // both producers streaming
    cyc();
    log_q.delete();
    mk = 1;
    ak = 17;
    for (int c = 0; c < 8; c++) begin
      put_mem(5'(mk), 16'(16'h1000 + mk));
      put_alu(5'(ak), 16'(16'h2000 + ak));
      #1;
      if (c == 1) begin
        chk("stream_full_cnt", 32'(wb_count), 32'(DEPTH));
        chk("stream_full_mrdy", 32'(mem_if.ready), 32'd0);
      end
      if (c == 2) begin
        chk("stream_mrdy", 32'(mem_if.ready), 32'd1);
        chk("stream_ardy", 32'(alu_if.ready), 32'd0);
      end
      mr = m_mem_ready();
      ar = m_alu_ready();
      cyc();
      if (mr) mk++;
      if (ar) ak++;
    end
    idle();
    repeat (4) cyc();
    @(negedge clk);
    chk("stream_log_n", 32'(log_q.size() >= 4), 32'd1);
    if (log_q.size() >= 4) begin
      chk("stream_c0", 32'(log_q[0].rd), 32'd1);
      chk("stream_c1", 32'(log_q[1].rd), 32'd17);
      chk("stream_c2", 32'(log_q[2].rd), 32'd2);
      chk("stream_c3", 32'(log_q[3].rd), 32'd3);
      chk("stream_d1", 32'(log_q[1].data), 32'h2011);
    end

    // full queue, one producer, pop in same cycle
    cyc();
    log_q.delete();
    put_mem(5'd7, 16'h7777);
    put_alu(5'd8, 16'h8888);
    cyc();
    idle();
    put_mem(5'd9, 16'h9999);
    @(negedge clk);
    chk("full_cnt", 32'(wb_count), 32'd2);
    chk("full_mrdy", 32'(mem_if.ready), 32'd0);
    chk("full_ardy", 32'(alu_if.ready), 32'd0);
    cyc();
    @(negedge clk);
    chk("full_pop_cnt", 32'(wb_count), 32'd1);
    chk("full_pop_rd", 32'(wb_rd), 32'd7);
    chk("full_retry_rdy", 32'(mem_if.ready), 32'd1);
    cyc();
    idle();
    @(negedge clk);
    chk("full_acc_cnt", 32'(wb_count), 32'd1);
    chk("full_acc_rd", 32'(wb_rd), 32'd8);
    cyc();
    @(negedge clk);
    chk("full_last_rd", 32'(wb_rd), 32'd9);
    chk("full_last_cnt", 32'(wb_count), 32'd0);
    cyc();
    @(negedge clk);
    chk("full_log_n", 32'(log_q.size()), 32'd3);

    // reset while the queue is full
    cyc();
    put_mem(5'd11, 16'hAAAA);
    put_alu(5'd12, 16'hBBBB);
    cyc();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(wb_count), 32'd0);
    chk("mid_rst_we", 32'(wb_we), 32'd0);
    chk("mid_rst_rd", 32'(wb_rd), 32'd0);
    chk("mid_rst_data", 32'(wb_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    repeat (3) cyc();
    @(negedge clk);
    chk("mid_rst_stale", 32'(log_q.size()), 32'd0);

`ifdef WB_BYPASS_EN
    // bypass: youngest match wins, clears after commit
    cyc();
    byp_rs = 5'd5;
    put_mem(5'd5, 16'h1111);
    put_alu(5'd5, 16'h2222);
    cyc();
    idle();
    @(negedge clk);
    chk("byp_hit2", 32'(byp_hit), 32'd1);
    chk("byp_data2", 32'(byp_data), 32'h2222);
    cyc();
    @(negedge clk);
    chk("byp_hit1", 32'(byp_hit), 32'd1);
    chk("byp_data1", 32'(byp_data), 32'h2222);
    cyc();
    @(negedge clk);
    chk("byp_hit0", 32'(byp_hit), 32'd0);
    cyc();
    byp_rs = 5'd0;
    put_mem(5'd0, 16'h0F0F);
    cyc();
    idle();
    @(negedge clk);
    chk("byp_r0", 32'(byp_hit), 32'd0);
    repeat (2) cyc();
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      alu_if.valid = 1'($urandom_range(0, 1));
      mem_if.valid = 1'($urandom_range(0, 1));
      alu_if.rd    = 5'($urandom);
      mem_if.rd    = 5'($urandom);
      alu_if.data  = 16'($urandom);
      mem_if.data  = 16'($urandom);
`ifdef WB_BYPASS_EN
      byp_rs = 5'($urandom_range(0, 7));
      if (c % 8 == 0) begin
        alu_if.rd = 5'($urandom_range(0, 7));
        mem_if.rd = 5'($urandom_range(0, 7));
      end
`endif
      cyc();
    end
    idle();
    repeat (4) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side front end for the 16-bit, 32-entry register file. Accepts completed results from the ALU and memory units over valid/ready handshakes, buffers them in an in-order queue, and drives the register file's destination index and write data, one commit per clock. The register file writes unconditionally on every falling edge, so this block also holds its outputs stable with the last committed value when idle, making the idle rewrite harmless.

## Interface
- DEPTH, 4, queue entries; power of two, at least 2
- DATA_W, 16, result width
- ADDR_W, 5, register index width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- alu_valid  in  1  ALU result offered
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU result accepted this cycle when high with alu_valid
- mem_valid, mem_rd, mem_data, mem_ready  same as ALU set, for the memory unit
- wb_rd  out  ADDR_W  to register file rd
- wb_data  out  DATA_W  to register file data_in
- wb_we  out  1  high for exactly the cycle a new commit is presented
- wb_count  out  log2(DEPTH)+1  entries currently queued
- byp_rs  in  ADDR_W  bypass lookup index (WB_BYPASS_EN only)
- byp_hit  out  1  a queued entry targets byp_rs (WB_BYPASS_EN only)
- byp_data  out  DATA_W  youngest queued value for byp_rs (WB_BYPASS_EN only)

## Operation
- Reset: queue empty, wb_count=0, wb_rd=0, wb_data=0, wb_we=0. Register 0 reads as zero by ISA convention, so writing 0 to r0 during reset and idle is benign.
- Readiness comes from free = DEPTH − wb_count at the start of the cycle. It ignores same-cycle pops and is purely combinational from state and the valid inputs.
  - mem_ready = (free ≥ 1)
  - alu_ready = (free ≥ 2) or (free ≥ 1 and not mem_valid)
- Simultaneous acceptance: MEM is enqueued first and is the older entry; ALU is enqueued second.
- Pop: at each rising edge, if the queue held ≥1 entry before this edge, the head moves into the wb_rd/wb_data registers and wb_we=1. Otherwise wb_rd/wb_data hold their values and wb_we=0.
- Count update: wb_count_next = wb_count + accepted (0..2) − popped (0..1). Push and pop in the same cycle are legal at any occupancy, including full with a pop.
- Ordering: commits leave in strict acceptance order. There is no merging or cancellation of same-rd entries.
- Pointers wrap modulo DEPTH. Full and empty are resolved from wb_count, not from pointer equality.
- Reset asserted mid-operation: all queued entries are discarded immediately and outputs return to their reset values asynchronously.

## Timing
- Entry accepted at edge N into an empty queue: presented on wb_rd/wb_data/wb_we after edge N+1. The register file latches it at the falling edge inside cycle N+1, and a register-file read at edge N+2 returns it.
- No flow-through: an entry is never popped on its acceptance edge.
- Sustained throughput: one commit per cycle. Two producers are sustained only while the queue has headroom.
- The ready outputs have no combinational path from wb outputs.

## Configuration
- WB_BYPASS_EN defined:
  - byp_rs/byp_hit/byp_data ports exist.
  - byp_hit=1 when any queued entry (not the wb output register) has rd == byp_rs.
  - byp_data comes from the youngest matching entry.
  - Both outputs are combinational.
  - byp_rs=0 always gives byp_hit=0.
  - The value in the wb output register needs no bypass, because it is written before the next read edge.
- WB_BYPASS_EN undefined: the three ports and the match logic are absent; everything else is identical.

## Structure
- Package wb_pkg: DATA_W/ADDR_W defaults and the entry struct type {rd, data}.
- Sub-module wb_fifo: DEPTH-entry circular buffer with two-write/one-read ports, count output, and (under WB_BYPASS_EN) a per-entry match vector with age-ordered select.
- Top level: ready logic, write ordering, and the output registers.

## Test plan
- Reset: hold rst_n=0 with random valids → wb_rd=0, wb_data=0, wb_we=0, wb_count=0, and both readys high after release.
- Single ALU write {rd=3, data=16'h00A5} at edge N → wb_we=1 with rd=3/0x00A5 in cycle N+1 only. Afterwards outputs hold 3/0x00A5 with wb_we=0.
- Both valid every cycle, MEM rd=1..n, ALU rd=17..: commit order is MEM1, ALU17, MEM2, ALU18…; alu_ready drops first; wb_count saturates at DEPTH and never overflows.
- Full queue with one producer valid and a pop in the same cycle → no acceptance that cycle (free=0), accepted next cycle, wb_count stays consistent, no entry lost or duplicated.
- Reset pulsed while 3 entries are queued → queue cleared; no stale commit after release.
- WB_BYPASS_EN: queue rd=5 values 0x1111 then 0x2222, set byp_rs=5 → byp_hit=1 and byp_data=0x2222. After both commit → byp_hit=0. byp_rs=0 → byp_hit=0 always.
